// File: rtl/packet_mac_swap.sv
// Egress MAC swapper: exchanges destination/source MAC (bytes 0-11) of every frame on a 64-bit AXIS bus.
// Optional live frame counters are built only when MAC_SWAP_STATS_EN is defined.
module packet_mac_swap #(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 4
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [AXIS_BUS_WIDTH-1:0]    axis_in_tdata,
  input  logic [AXIS_BUS_WIDTH/8-1:0]  axis_in_tkeep,
  input  logic [AXIS_ID_WIDTH-1:0]     axis_in_tid,
  input  logic [AXIS_DEST_WIDTH-1:0]   axis_in_tdest,
  input  logic                         axis_in_tlast,
  input  logic                         axis_in_tvalid,
  output logic                         axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]    axis_out_tdata,
  output logic [AXIS_BUS_WIDTH/8-1:0]  axis_out_tkeep,
  output logic [AXIS_ID_WIDTH-1:0]     axis_out_tid,
  output logic [AXIS_DEST_WIDTH-1:0]   axis_out_tdest,
  output logic                         axis_out_tlast,
  output logic                         axis_out_tvalid,
  input  logic                         axis_out_tready,
  output logic [31:0]                  swapped_count,
  output logic [31:0]                  runt_count
);

  localparam int KW = AXIS_BUS_WIDTH / 8;

  generate
    if (AXIS_BUS_WIDTH != 64) begin : g_bad_width
      $error("packet_mac_swap supports AXIS_BUS_WIDTH = 64 only");
    end
  endgenerate

  // Handshake: a beat moves on a port in every cycle where tvalid and tready are both high
  // at the rising edge; the output side never changes data or sideband while tvalid & ~tready.

  logic                        head;
  logic                        a_valid, a_head, a_last;
  logic [AXIS_BUS_WIDTH-1:0]   a_data;
  logic [KW-1:0]               a_keep;
  logic [AXIS_ID_WIDTH-1:0]    a_id;
  logic [AXIS_DEST_WIDTH-1:0]  a_dest;

  logic                        b_valid, b_last;
  logic [AXIS_BUS_WIDTH-1:0]   b_data;
  logic [KW-1:0]               b_keep;
  logic [AXIS_ID_WIDTH-1:0]    b_id;
  logic [AXIS_DEST_WIDTH-1:0]  b_dest;

  logic                        b_free, a_adv, in_ready, in_fire, swap;
  logic [AXIS_BUS_WIDTH-1:0]   a_next_data, b_next_data;

  always_comb begin
    b_free   = ~b_valid | axis_out_tready;
    // A head beat that is not the last beat may only leave together with beat 1.
    a_adv    = a_valid & b_free & (~a_head | a_last | axis_in_tvalid);
    in_ready = ~areset & (~a_valid | a_adv);
    in_fire  = axis_in_tvalid & in_ready;
    swap     = a_adv & a_head & ~a_last & in_fire & (axis_in_tkeep[3:0] == 4'hF);
    b_next_data = a_data;
    a_next_data = axis_in_tdata;
    if (swap) begin
      // Beat 0 becomes src MAC (b6,b7,c0..c3) then dst bytes b0,b1; beat 1 starts with b2..b5.
      b_next_data = {a_data[15:0], axis_in_tdata[31:0], a_data[63:48]};
      a_next_data = {axis_in_tdata[63:32], a_data[47:16]};
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      head    <= 1'b1;
      a_valid <= 1'b0;
      a_head  <= 1'b0;
      a_last  <= 1'b0;
      a_data  <= '0;
      a_keep  <= '0;
      a_id    <= '0;
      a_dest  <= '0;
    end else begin
      if (in_fire) begin
        head    <= axis_in_tlast;
        a_valid <= 1'b1;
        a_head  <= head;
        a_last  <= axis_in_tlast;
        a_data  <= a_next_data;
        a_keep  <= axis_in_tkeep;
        a_id    <= axis_in_tid;
        a_dest  <= axis_in_tdest;
      end else if (a_adv) begin
        a_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      b_valid <= 1'b0;
      b_last  <= 1'b0;
      b_data  <= '0;
      b_keep  <= '0;
      b_id    <= '0;
      b_dest  <= '0;
    end else begin
      if (a_adv) begin
        b_valid <= 1'b1;
        b_last  <= a_last;
        b_data  <= b_next_data;
        b_keep  <= a_keep;
        b_id    <= a_id;
        b_dest  <= a_dest;
      end else if (axis_out_tready) begin
        b_valid <= 1'b0;
      end
    end
  end

  assign axis_in_tready  = in_ready;
  assign axis_out_tvalid = b_valid;
  assign axis_out_tdata  = b_data;
  assign axis_out_tkeep  = b_keep;
  assign axis_out_tid    = b_id;
  assign axis_out_tdest  = b_dest;
  assign axis_out_tlast  = b_last;

`ifdef MAC_SWAP_STATS_EN
  logic        runt;
  logic [31:0] swapped_q, runt_q;

  // A head beat leaving A without a swap is a runt: single-beat frame or short beat 1.
  assign runt = a_adv & a_head & ~swap;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      swapped_q <= '0;
      runt_q    <= '0;
    end else begin
      if (swap) swapped_q <= swapped_q + 32'd1;
      if (runt) runt_q    <= runt_q + 32'd1;
    end
  end

  assign swapped_count = swapped_q;
  assign runt_count    = runt_q;
`else
  assign swapped_count = 32'd0;
  assign runt_count    = 32'd0;
`endif

endmodule

// File: tb/tb_packet_mac_swap.sv
// Bench for packet_mac_swap: byte-level frame model feeds an expected-beat queue checked by an output monitor.
module tb_packet_mac_swap;

  localparam int EW = 4 + 4 + 1 + 8 + 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] axis_in_tdata = '0;
  logic [7:0]  axis_in_tkeep = '0;
  logic [3:0]  axis_in_tid = '0;
  logic [3:0]  axis_in_tdest = '0;
  logic        axis_in_tlast = 1'b0;
  logic        axis_in_tvalid = 1'b0;
  logic        axis_in_tready;
  logic [63:0] axis_out_tdata;
  logic [7:0]  axis_out_tkeep;
  logic [3:0]  axis_out_tid;
  logic [3:0]  axis_out_tdest;
  logic        axis_out_tlast;
  logic        axis_out_tvalid;
  logic        axis_out_tready = 1'b0;
  logic [31:0] swapped_count;
  logic [31:0] runt_count;

  packet_mac_swap #(.AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(4), .AXIS_DEST_WIDTH(4)) dut (
    .aclk(clk), .areset(rst),
    .axis_in_tdata(axis_in_tdata), .axis_in_tkeep(axis_in_tkeep), .axis_in_tid(axis_in_tid),
    .axis_in_tdest(axis_in_tdest), .axis_in_tlast(axis_in_tlast), .axis_in_tvalid(axis_in_tvalid),
    .axis_in_tready(axis_in_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tkeep(axis_out_tkeep), .axis_out_tid(axis_out_tid),
    .axis_out_tdest(axis_out_tdest), .axis_out_tlast(axis_out_tlast), .axis_out_tvalid(axis_out_tvalid),
    .axis_out_tready(axis_out_tready),
    .swapped_count(swapped_count), .runt_count(runt_count)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];
  int exp_sw = 0;
  int exp_rn = 0;
  bit rand_ready = 1'b0;
  bit fixed_ready = 1'b1;
  bit gap_en = 1'b0;
  int first_acc_edge = -1;
  int last_out_edge = 0;
  int out_count = 0;
  logic [7:0] mac_hdr [12];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // ---------------- output ready driver ----------------
  initial begin
    forever begin
      @(negedge clk);
      axis_out_tready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] cur;
    logic [EW-1:0] prev;
    bit prev_stall;
    prev = '0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      cur = {axis_out_tid, axis_out_tdest, axis_out_tlast, axis_out_tkeep, axis_out_tdata};
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("stall_hold", {axis_out_tvalid, cur}, {1'b1, prev});
        if (axis_out_tvalid && axis_out_tready) begin
          out_count++;
          last_out_edge = cyc + 1;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_beat: got unexpected beat %h, expected no beat", cur);
          end else begin
            check("out_beat", cur, exp_q.pop_front());
          end
        end
        prev_stall = axis_out_tvalid && !axis_out_tready;
        prev = cur;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic [3:0] id, input logic [3:0] de);
    int waitc;
    waitc = 0;
    if (gap_en && $urandom_range(0, 5) == 0) begin
      @(negedge clk);
      axis_in_tvalid = 1'b0;
    end
    @(negedge clk);
    axis_in_tvalid = 1'b1;
    axis_in_tdata  = d;
    axis_in_tkeep  = k;
    axis_in_tlast  = l;
    axis_in_tid    = id;
    axis_in_tdest  = de;
    #1;
    while (!axis_in_tready && waitc < 2000) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (!axis_in_tready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_accept: tready low for %0d cycles, expected high", waitc);
    end else if (first_acc_edge < 0) begin
      first_acc_edge = cyc + 1;
    end
  endtask

  // Builds a frame of len bytes, pushes its expected beats, then drives it
  // (only the first stop_beats beats when stop_beats >= 0).
  task automatic send_frame(input int len, input int stop_beats, input bit mac_test);
    logic [7:0] bytes[$];
    logic [7:0] ex[$];
    logic [7:0] tmp;
    logic [63:0] d;
    logic [7:0] k;
    logic [8:0] t;
    logic [3:0] fid, fdest;
    int nb;
    nb = (len + 7) / 8;
    fid = 4'($urandom_range(0, 15));
    fdest = 4'($urandom_range(0, 15));
    for (int i = 0; i < nb * 8; i++) bytes.push_back(8'($urandom_range(0, 255)));
    if (mac_test) for (int i = 0; i < 12; i++) bytes[i] = mac_hdr[i];
    ex = bytes;
    if (len >= 12) begin
      for (int i = 0; i < 6; i++) begin
        tmp = ex[i];
        ex[i] = ex[i + 6];
        ex[i + 6] = tmp;
      end
      exp_sw++;
    end else begin
      exp_rn++;
    end
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 8; j++) d[j*8 +: 8] = ex[b*8 + j];
      t = 9'(1) << (len - b * 8 >= 8 ? 8 : len - b * 8);
      k = t[7:0] - 8'd1;
      exp_q.push_back({fid, fdest, (b == nb - 1), k, d});
    end
    for (int b = 0; b < nb && (stop_beats < 0 || b < stop_beats); b++) begin
      for (int j = 0; j < 8; j++) d[j*8 +: 8] = bytes[b*8 + j];
      t = 9'(1) << (len - b * 8 >= 8 ? 8 : len - b * 8);
      k = t[7:0] - 8'd1;
      send_beat(d, k, (b == nb - 1), fid, fdest);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    axis_in_tvalid = 1'b0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_counts();
`ifdef MAC_SWAP_STATS_EN
    check("swapped_count", swapped_count, 32'(exp_sw));
    check("runt_count", runt_count, 32'(exp_rn));
`else
    check("swapped_count", swapped_count, 0);
    check("runt_count", runt_count, 0);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int total;
    int out0;
    int len;
    mac_hdr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", axis_out_tvalid, 0);
    check("reset_out_fields", {axis_out_tid, axis_out_tdest, axis_out_tlast, axis_out_tkeep, axis_out_tdata}, 0);
    check("reset_in_ready", axis_in_tready, 0);
    check_counts();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", axis_in_tready, 1);

    // directed: 64-byte frame with known MACs
    fixed_ready = 1'b1;
    send_frame(64, -1, 1'b1);
    wait_drain();
    check_counts();

    // single-beat runt and short beat 1 runt
    send_frame(8, -1, 1'b0);
    wait_drain();
    check_counts();
    send_frame(10, -1, 1'b0);
    wait_drain();
    check_counts();

    // random long frames with random backpressure and input gaps
    rand_ready = 1'b1;
    gap_en = 1'b1;
    for (int f = 0; f < 100; f++) send_frame($urandom_range(64, 1518), -1, 1'b0);
    wait_drain();
    check_counts();
    for (int f = 0; f < 30; f++) send_frame($urandom_range(1, 20), -1, 1'b0);
    wait_drain();
    check_counts();
    rand_ready = 1'b0;
    gap_en = 1'b0;

    // continuous stream at full rate
    fixed_ready = 1'b1;
    repeat (2) @(negedge clk);
    first_acc_edge = -1;
    out0 = out_count;
    total = 0;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 100);
      total += (len + 7) / 8;
      send_frame(len, -1, 1'b0);
    end
    wait_drain();
    check("stream_beat_count", out_count - out0, total);
    check("stream_span_cycles", last_out_edge - first_acc_edge, total + 1);
    check_counts();

    // reset in the middle of a frame
    send_frame(64, 4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    axis_in_tvalid = 1'b0;
    #1;
    check("midreset_out_valid", axis_out_tvalid, 0);
    check("midreset_in_ready", axis_in_tready, 0);
    exp_q.delete();
    exp_sw = 0;
    exp_rn = 0;
    repeat (2) @(negedge clk);
    #1;
    check("midreset_out_valid_hold", axis_out_tvalid, 0);
    check_counts();
    @(negedge clk);
    rst = 1'b0;
    send_frame(64, -1, 1'b1);
    wait_drain();
    check_counts();
    send_frame($urandom_range(64, 300), -1, 1'b0);
    wait_drain();
    check_counts();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
